// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back path.
// Entries carry a live bit so younger ALU writes can cancel them in place.
package wb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  live;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Result sources, hazard query and register-file write port
// bundled between the pipeline and the write-back arbiter.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4
);

  localparam int DW = wb_pkg::DATA_WIDTH;
  localparam int AW = wb_pkg::ADDR_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          Alu_Valid_i;
  logic [AW-1:0] Alu_Rd_i;
  logic [DW-1:0] Alu_Data_i;
  logic          Mdu_Valid_i;
  logic          Mdu_Ready_o;
  logic [AW-1:0] Mdu_Rd_i;
  logic [DW-1:0] Mdu_Data_i;
  logic [AW-1:0] Read_Register_1_i;
  logic [AW-1:0] Read_Register_2_i;
  logic          Hazard_1_o;
  logic          Hazard_2_o;
  logic          Reg_Write_o;
  logic [AW-1:0] Write_Register_o;
  logic [DW-1:0] Write_Data_o;
  logic [CW-1:0] Pending_o;

  modport slave (
    input  Alu_Valid_i, Alu_Rd_i, Alu_Data_i,
    input  Mdu_Valid_i, Mdu_Rd_i, Mdu_Data_i,
    input  Read_Register_1_i, Read_Register_2_i,
    output Mdu_Ready_o, Hazard_1_o, Hazard_2_o,
    output Reg_Write_o, Write_Register_o,
    output Write_Data_o, Pending_o
  );

  modport master (
    output Alu_Valid_i, Alu_Rd_i, Alu_Data_i,
    output Mdu_Valid_i, Mdu_Rd_i, Mdu_Data_i,
    output Read_Register_1_i, Read_Register_2_i,
    input  Mdu_Ready_o, Hazard_1_o, Hazard_2_o,
    input  Reg_Write_o, Write_Register_o,
    input  Write_Data_o, Pending_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of MDU results with kill-by-rd and
// per-entry live/rd match vectors for hazard detection.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_rd,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [ADDR_WIDTH-1:0] kill_rd,
  input  logic [ADDR_WIDTH-1:0] rd1,
  input  logic [ADDR_WIDTH-1:0] rd2,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      match1,
  output logic [DEPTH-1:0]      match2,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // live doubles as occupancy: cleared on pop, so
  // stale slots never match a hazard query
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && mem[i].rd == kill_rd)
          mem[i].live <= 1'b0;
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= '{live: 1'b1,
                         rd:   push_rd,
                         data: push_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = mem[i].live && mem[i].rd == rd1;
      match2[i] = mem[i].live && mem[i].rd == rd2;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: ALU first, buffered MDU
// results drained in idle slots, pending-write hazard flags.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_write_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t             head;
  logic [DEPTH-1:0]      match1;
  logic [DEPTH-1:0]      match2;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  alu_wr;
  logic                  push;
  logic                  pop;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] wreg;
  logic [DATA_WIDTH-1:0] wdata;

  assign alu_wr = bus.Alu_Valid_i && bus.Alu_Rd_i != REG_ZERO;
  assign pop    = !alu_wr && !empty;

  // the ALU op is younger, so a same-rd MDU result is dead on arrival
  assign push = bus.Mdu_Valid_i && !full
             && bus.Mdu_Rd_i != REG_ZERO
             && !(alu_wr && bus.Mdu_Rd_i == bus.Alu_Rd_i);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .push_rd   (bus.Mdu_Rd_i),
    .push_data (bus.Mdu_Data_i),
    .pop       (pop),
    .kill      (alu_wr),
    .kill_rd   (bus.Alu_Rd_i),
    .rd1       (bus.Read_Register_1_i),
    .rd2       (bus.Read_Register_2_i),
    .head      (head),
    .match1    (match1),
    .match2    (match2),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write <= 1'b0;
      wreg      <= '0;
      wdata     <= '0;
    end else begin
      reg_write <= 1'b0;
      if (alu_wr) begin
        reg_write <= 1'b1;
        wreg      <= bus.Alu_Rd_i;
        wdata     <= bus.Alu_Data_i;
      end else if (pop && head.live) begin
        reg_write <= 1'b1;
        wreg      <= head.rd;
        wdata     <= head.data;
      end
    end
  end

  assign bus.Reg_Write_o      = reg_write;
  assign bus.Write_Register_o = wreg;
  assign bus.Write_Data_o     = wdata;
  assign bus.Pending_o        = count;
  assign bus.Mdu_Ready_o      = !full;

  assign bus.Hazard_1_o = bus.Read_Register_1_i != REG_ZERO
    && (|match1 || (reg_write && wreg == bus.Read_Register_1_i));
  assign bus.Hazard_2_o = bus.Read_Register_2_i != REG_ZERO
    && (|match2 || (reg_write && wreg == bus.Read_Register_2_i));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed vector bench for wb_write_arbiter: table rows plus
// a hand-written reset-during-drain sequence.
module tb_wb_write_arbiter;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DEPTH(4)) bus ();

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic [2:0]  e_pend;
    logic        e_h1;
    logic        e_h2;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic rdy, input logic rw, input logic [4:0] wr,
    input logic [31:0] wd, input logic [2:0] pend,
    input logic h1, input logic h2);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.r1 = r1; v.r2 = r2;
    v.e_rdy = rdy; v.e_rw = rw; v.e_wr = wr; v.e_wd = wd;
    v.e_pend = pend; v.e_h1 = h1; v.e_h2 = h2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic mv,
                       input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.Alu_Valid_i       = av;
    bus.Alu_Rd_i          = ard;
    bus.Alu_Data_i        = ad;
    bus.Mdu_Valid_i       = mv;
    bus.Mdu_Rd_i          = mrd;
    bus.Mdu_Data_i        = md;
    bus.Read_Register_1_i = r1;
    bus.Read_Register_2_i = r2;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    @(negedge clk);
    drive(v.av, v.ard, v.ad, v.mv, v.mrd, v.md, v.r1, v.r2);
    @(posedge clk);
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".ready"}, 32'(bus.Mdu_Ready_o), 32'(v.e_rdy));
    chk({tag, ".rw"},    32'(bus.Reg_Write_o), 32'(v.e_rw));
    chk({tag, ".wr"},    32'(bus.Write_Register_o), 32'(v.e_wr));
    chk({tag, ".wd"},    bus.Write_Data_o, v.e_wd);
    chk({tag, ".pend"},  32'(bus.Pending_o), 32'(v.e_pend));
    chk({tag, ".h1"},    32'(bus.Hazard_1_o), 32'(v.e_h1));
    chk({tag, ".h2"},    32'(bus.Hazard_2_o), 32'(v.e_h2));
  endtask

  initial begin
    //          av ard ad            mv mrd md         r1 r2  rdy rw wr wd            pd h1 h2
    // ALU only
    tbl[0]  = mk(1, 5, 32'hA5A5A5A5, 0, 0, 0,         5, 0,  1, 1, 5, 32'hA5A5A5A5, 0, 1, 0);
    // fill FIFO rd 1..4 under a busy ALU
    tbl[1]  = mk(1, 10, 32'h10,      1, 1, 32'h101,   0, 0,  1, 1, 10, 32'h10,      1, 0, 0);
    tbl[2]  = mk(1, 11, 32'h11,      1, 2, 32'h102,   0, 0,  1, 1, 11, 32'h11,      2, 0, 0);
    tbl[3]  = mk(1, 12, 32'h12,      1, 3, 32'h103,   0, 0,  1, 1, 12, 32'h12,      3, 0, 0);
    tbl[4]  = mk(1, 13, 32'h13,      1, 4, 32'h104,   3, 13, 0, 1, 13, 32'h13,      4, 1, 1);
    // drain; offer while full is refused
    tbl[5]  = mk(0, 0, 0,            1, 6, 32'h106,   3, 6,  1, 1, 1, 32'h101,      3, 1, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,         3, 2,  1, 1, 2, 32'h102,      2, 1, 1);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,         3, 2,  1, 1, 3, 32'h103,      1, 1, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,         3, 4,  1, 1, 4, 32'h104,      0, 0, 1);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0,         3, 4,  1, 0, 4, 32'h104,      0, 0, 0);
    // kill: MDU rd7 then ALU rd7
    tbl[10] = mk(0, 0, 0,            1, 7, 32'h11,    7, 0,  1, 0, 4, 32'h104,      1, 1, 0);
    tbl[11] = mk(1, 7, 32'h22,       0, 0, 0,         7, 0,  1, 1, 7, 32'h22,       1, 1, 0);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,         7, 0,  1, 0, 7, 32'h22,       0, 0, 0);
    // same-cycle same-rd push dropped
    tbl[13] = mk(1, 8, 32'h33,       1, 8, 32'h44,    8, 0,  1, 1, 8, 32'h33,       0, 1, 0);
    tbl[14] = mk(0, 0, 0,            0, 0, 0,         8, 0,  1, 0, 8, 32'h33,       0, 0, 0);
    // register 0 handling
    tbl[15] = mk(0, 0, 0,            1, 0, 32'h55,    0, 0,  1, 0, 8, 32'h33,       0, 0, 0);
    tbl[16] = mk(0, 0, 0,            1, 3, 32'h303,   3, 0,  1, 0, 8, 32'h33,       1, 1, 0);
    tbl[17] = mk(1, 0, 32'h99,       0, 0, 0,         3, 0,  1, 1, 3, 32'h303,      0, 1, 0);
    tbl[18] = mk(0, 0, 0,            0, 0, 0,         3, 0,  1, 0, 3, 32'h303,      0, 0, 0);
    // hazard on buffered rd9
    tbl[19] = mk(1, 14, 32'h14,      1, 9, 32'h909,   9, 0,  1, 1, 14, 32'h14,      1, 1, 0);
    tbl[20] = mk(1, 15, 32'h15,      0, 0, 0,         9, 0,  1, 1, 15, 32'h15,      1, 1, 0);
    tbl[21] = mk(0, 0, 0,            0, 0, 0,         9, 0,  1, 1, 9, 32'h909,      0, 1, 0);
    tbl[22] = mk(0, 0, 0,            0, 0, 0,         9, 0,  1, 0, 9, 32'h909,      0, 0, 0);
    // push and pop in one cycle
    tbl[23] = mk(1, 16, 32'h16,      1, 1, 32'h1AA,   0, 0,  1, 1, 16, 32'h16,      1, 0, 0);
    tbl[24] = mk(0, 0, 0,            1, 2, 32'h2BB,   2, 0,  1, 1, 1, 32'h1AA,      1, 1, 0);
    tbl[25] = mk(0, 0, 0,            0, 0, 0,         2, 0,  1, 1, 2, 32'h2BB,      0, 1, 0);
    tbl[26] = mk(0, 0, 0,            0, 0, 0,         2, 0,  1, 0, 2, 32'h2BB,      0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rw",    32'(bus.Reg_Write_o), 0);
    chk("rst.wr",    32'(bus.Write_Register_o), 0);
    chk("rst.wd",    bus.Write_Data_o, 0);
    chk("rst.pend",  32'(bus.Pending_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst.ready", 32'(bus.Mdu_Ready_o), 1);

    for (int i = 0; i < NV; i++)
      run_vec(i, tbl[i]);

    // reset while draining with three entries left
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 5'(24 + i), 32'(i), 1, 5'(20 + i),
            32'h2000 + 32'(i), 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("md.rw",   32'(bus.Reg_Write_o), 1);
    chk("md.wr",   32'(bus.Write_Register_o), 20);
    chk("md.pend", 32'(bus.Pending_o), 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("md.rst.rw",   32'(bus.Reg_Write_o), 0);
    chk("md.rst.wr",   32'(bus.Write_Register_o), 0);
    chk("md.rst.wd",   bus.Write_Data_o, 0);
    chk("md.rst.pend", 32'(bus.Pending_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post%0d.rw", i), 32'(bus.Reg_Write_o), 0);
      chk($sformatf("post%0d.pend", i), 32'(bus.Pending_o), 0);
      chk($sformatf("post%0d.ready", i), 32'(bus.Mdu_Ready_o), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
